// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: handshake and data bundle for the shift-add multiplier sequencer.
//   start, a, b : operand source -> sequencer (start sampled only while ready=1)
//   ready, busy : sequencer status (IDLE / RUN)
//   done, z     : one-cycle completion pulse and held 2N-bit product
//   idx         : current partial-product row (observability only)
// master = operand source/consumer side, slave = sequencer side.
interface mult_seq_ctrl_if #(
   parameter int unsigned N = 4
);
   localparam int unsigned ZW = 2 * N;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic          start;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          ready;
   logic          busy;
   logic          done;
   logic [ZW-1:0] z;
   logic [IW-1:0] idx;

   modport master (
      output start, a, b,
      input  ready, busy, done, z, idx
   );

   modport slave (
      input  start, a, b,
      output ready, busy, done, z, idx
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: multi-cycle unsigned shift-add multiplier sequencer.
// One operand pair is captured per accepted start; each RUN cycle adds one
// partial-product row (a & b[i]) << i into a 2N-bit accumulator. After the
// last row the product is loaded into z and done pulses for one cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : mult_seq_ctrl_if.slave (start/a/b in; ready/busy/done/z/idx out)
// Optional build macro MULT_SEQ_EARLY_EXIT_EN: finish as soon as no set
// multiplier bits remain above the current row.
module mult_seq_ctrl #(
   parameter int unsigned N = 4
) (
   input  logic            clk,
   input  logic            rst,
   mult_seq_ctrl_if.slave  bus
);
   localparam int unsigned ZW = 2 * N;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [ZW-1:0] acc_q, acc_d;
   logic [ZW-1:0] z_q, z_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [ZW-1:0] row_add;
   logic [ZW-1:0] acc_sum;
   logic          last_row;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      z_d     = z_q;
      idx_d   = idx_q;

      // Partial-product row for the current index, zero-extended before shifting
      row_add  = b_q[idx_q] ? (ZW'(a_q) << idx_q) : '0;
      acc_sum  = acc_q + row_add;
`ifdef MULT_SEQ_EARLY_EXIT_EN
      // Stop once no multiplier bits remain above this row; skipped rows add zero
      last_row = (idx_q == IW'(N - 1)) || (((b_q >> idx_q) >> 1) == N'(0));
`else
      last_row = (idx_q == IW'(N - 1));
`endif

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_sum;
            if (last_row) begin
               z_d     = acc_sum;
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = IW'(idx_q + 1'b1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered versions of the next state
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         z_q     <= '0;
         idx_q   <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
         idx_q   <= idx_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.z     = z_q;
   assign bus.idx   = idx_q;

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle shift-add multiplier sequencer.
- Takes one operand pair per start handshake and accumulates one partial product row (a AND b[i], shifted left by i) per clock into a 2N-bit accumulator.
- Produces the full product after N RUN cycles, for area-constrained paths where the parallel array multiplier is too large or too slow.
- Sits between an operand source and consumer, with a start/ready/done handshake.

Parameters:
- N, 4, operand width in bits (N >= 2); product width is 2N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin a multiply; sampled only when ready=1
- a  input  N  multiplicand; captured on the accepted start
- b  input  N  multiplier; captured on the accepted start
- ready  output  1  high in IDLE; the block can accept start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; z holds the new product
- z  output  2N  registered product; holds its value until the next completion
- idx  output  clog2(N)  current partial-product row index (debug/observability)

Behaviour:
- Single clock, all state updated on the rising edge of clk. rst is synchronous, active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, z=0, idx=0, accumulator=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - If start=1 at the edge: capture a_reg=a and b_reg=b, clear acc=0, set idx=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1.
  - Each edge: if b_reg[idx]=1 then acc <= acc + (zero-extended a_reg << idx); else acc is unchanged. idx increments.
  - On the edge that processes idx=N-1: go to DONE, load z <= final accumulated value, reset idx to 0.
- DONE:
  - done=1 for exactly one cycle; ready=0, busy=0.
  - Next edge unconditionally returns to IDLE.
- Latency: start accepted at edge k -> done high and z valid after edge k+N. ready is high again after edge k+N+1.
- Throughput: one product per N+2 cycles (back-to-back start).
- start while RUN or DONE: ignored, no queuing; the caller must hold or reissue start once ready=1.
- a/b changes after acceptance have no effect on the operation in progress.
- Arithmetic:
  - Unsigned only.
  - acc is 2N bits. The maximum product (2^N-1)^2 fits in 2N bits, so no overflow or carry-out is required.
  - Shifts zero-fill.
- z is updated only on entry to DONE; it holds through IDLE and RUN of the next operation.
- rst during RUN or DONE:
  - Abort immediately to IDLE.
  - z=0 and done=0 on the following cycle; no done pulse is emitted for the aborted operation.
- rst and start both high: rst wins; start is not accepted.

Optional Feature:
- Macro: MULT_SEQ_EARLY_EXIT_EN.
- Defined:
  - After processing row idx, if b_reg bits above idx are all zero, go to DONE on that same edge.
  - Latency becomes (index of the highest set bit of b)+1 edges, minimum 1; b=0 completes in 1 edge with z=0.
  - Skipped rows do not change acc, so results are identical to the full sequence.
- Not defined: every operation runs exactly N RUN cycles regardless of operand values.

Test Plan:
- N=4, a=3, b=5, start pulse -> done pulses exactly 4 edges after acceptance, z=15, ready returns the next cycle; z still 15 during the following IDLE.
- N=4, a=15, b=15 -> z=225 (8'hE1); N=4, a=0, b=9 -> z=0 with a done pulse. Exhaustive loop over all 256 pairs -> z=a*b for each.
- start held high continuously with varying a/b -> each accepted pair corresponds to one done; products match operands captured at acceptance; new start is accepted only while ready=1; 6-cycle period.
- start reasserted with a=7, b=7 two cycles into a 3*5 operation -> ignored; done gives z=15, not 49.
- rst asserted on the 2nd RUN cycle of 9*9 -> next cycle state=IDLE, ready=1, z=0, no done pulse; a fresh 2*6 then gives z=12.
- With MULT_SEQ_EARLY_EXIT_EN defined: a=13, b=1 -> done 1 edge after acceptance, z=13; a=13, b=4 -> done after 3 edges, z=52. Without the macro, both complete after 4 edges.
